count_monitor: RTL and testbench

//   Receive-side checker for an up/down counter value stream, such as the
//   3-bit up/down counter. Samples the incoming count on each valid cycle and

---
 rtl/count_monitor.sv | 103 ++++++++++
 tb/tb_count_monitor.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/count_monitor.sv
// Receive-side checker for an up/down counter stream: classifies each valid
// sample as up/down/hold/jump, tracks lock, direction, wraps and step errors.
module count_monitor #(
    parameter int WIDTH      = 3,
    parameter int LOCK_STEPS = 4,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_count,
    output logic             locked,
    output logic             dir_valid,
    output logic             dir_up,
    output logic             step_err,
    output logic [WIDTH-1:0] wrap_cnt,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, ACQ, LOCKED, FAULT} state_t;

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [3:0]       LOCK_N   = 4'(LOCK_STEPS);

    state_t           state;
    logic [WIDTH-1:0] prev;
    logic [3:0]       good_run;

    logic [WIDTH-1:0] delta;
    logic             is_up;
    logic             is_down;
    logic             is_hold;
    logic             is_step;
    logic             is_wrap;

    // Modular difference makes the all-ones <-> zero transitions ordinary steps.
    assign delta   = in_count - prev;
    assign is_up   = (delta == ONE);
    assign is_down = (delta == ALL_ONES);
    assign is_hold = (delta == '0);
    assign is_step = is_up || is_down;
    assign is_wrap = (is_up && in_count == '0) || (is_down && in_count == ALL_ONES);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            prev      <= '0;
            good_run  <= '0;
            locked    <= 1'b0;
            dir_valid <= 1'b0;
            dir_up    <= 1'b0;
            step_err  <= 1'b0;
            wrap_cnt  <= '0;
            err_cnt   <= '0;
        end else begin
            dir_valid <= 1'b0;
            step_err  <= 1'b0;
            if (in_valid) begin
                prev <= in_count;
                case (state)
                    IDLE, FAULT: begin
                        // This sample is only a reference for the next one.
                        state    <= ACQ;
                        good_run <= '0;
                    end
                    ACQ: begin
                        if (is_step) begin
                            good_run  <= good_run + 4'd1;
                            dir_valid <= 1'b1;
                            dir_up    <= is_up;
                            if (good_run + 4'd1 == LOCK_N) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else if (!is_hold) begin
                            good_run <= '0;
                        end
                    end
                    LOCKED: begin
                        if (is_step) begin
                            dir_valid <= 1'b1;
                            dir_up    <= is_up;
                            if (is_wrap)
                                wrap_cnt <= wrap_cnt + ONE;
                        end else if (!is_hold) begin
                            step_err <= 1'b1;
                            locked   <= 1'b0;
                            state    <= FAULT;
                            if (err_cnt != '1)
                                err_cnt <= err_cnt + ERR_W'(1);
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor: a vector table for the main stream plus
// hand-written sequences for async reset and error-counter saturation.
module tb_count_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] in_count = 3'd0;

    logic       locked, dir_valid, dir_up, step_err;
    logic [2:0] wrap_cnt;
    logic [7:0] err_cnt;

    logic       s_locked, s_dir_valid, s_dir_up, s_step_err;
    logic [2:0] s_wrap_cnt;
    logic [1:0] s_err_cnt;

    int total = 0;
    int bad   = 0;

    count_monitor #(.WIDTH(3), .LOCK_STEPS(4), .ERR_W(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_count(in_count),
        .locked(locked), .dir_valid(dir_valid), .dir_up(dir_up),
        .step_err(step_err), .wrap_cnt(wrap_cnt), .err_cnt(err_cnt)
    );

    count_monitor #(.WIDTH(3), .LOCK_STEPS(4), .ERR_W(2)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_count(in_count),
        .locked(s_locked), .dir_valid(s_dir_valid), .dir_up(s_dir_up),
        .step_err(s_step_err), .wrap_cnt(s_wrap_cnt), .err_cnt(s_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [2:0] c;
        logic       l;
        logic       dv;
        logic       up;
        logic       se;
        logic [2:0] w;
        logic [7:0] e;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic v, logic [2:0] c, logic l, logic dv,
                                logic up, logic se, logic [2:0] w, logic [7:0] e);
        vec_t t;
        t.v = v; t.c = c; t.l = l; t.dv = dv; t.up = up; t.se = se; t.w = w; t.e = e;
        vecs.push_back(t);
    endfunction

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(string tag, logic l, logic dv, logic up, logic se,
                              logic [2:0] w, logic [7:0] e);
        check({tag, ".locked"},    int'(locked),    int'(l));
        check({tag, ".dir_valid"}, int'(dir_valid), int'(dv));
        check({tag, ".dir_up"},    int'(dir_up),    int'(up));
        check({tag, ".step_err"},  int'(step_err),  int'(se));
        check({tag, ".wrap_cnt"},  int'(wrap_cnt),  int'(w));
        check({tag, ".err_cnt"},   int'(err_cnt),   int'(e));
    endtask

    // Present one sample for a full cycle; outputs are sampled just after the edge.
    task automatic drive(logic v, logic [2:0] c);
        @(negedge clk);
        in_valid = v;
        in_count = c;
        @(posedge clk);
        #1;
        $display("t=%0t valid=%0d count=%0d -> locked=%0d dv=%0d up=%0d se=%0d wrap=%0d err=%0d",
                 $time, v, c, locked, dir_valid, dir_up, step_err, wrap_cnt, err_cnt);
    endtask

    initial begin
        logic [2:0] p;
        int exp_sat;

        //   v  c  l  dv up se w  e
        add(1, 0, 0, 0, 0, 0, 0, 0);   // reference only
        add(1, 1, 0, 1, 1, 0, 0, 0);
        add(1, 2, 0, 1, 1, 0, 0, 0);
        add(1, 3, 0, 1, 1, 0, 0, 0);
        add(1, 4, 1, 1, 1, 0, 0, 0);   // fourth step locks
        add(1, 5, 1, 1, 1, 0, 0, 0);
        add(1, 6, 1, 1, 1, 0, 0, 0);
        add(1, 7, 1, 1, 1, 0, 0, 0);
        add(1, 0, 1, 1, 1, 0, 1, 0);   // up wrap
        add(1, 7, 1, 1, 0, 0, 2, 0);   // down wrap
        add(1, 6, 1, 1, 0, 0, 2, 0);
        add(1, 5, 1, 1, 0, 0, 2, 0);
        add(1, 4, 1, 1, 0, 0, 2, 0);
        add(1, 3, 1, 1, 0, 0, 2, 0);
        add(1, 6, 0, 0, 0, 1, 2, 1);   // jump while locked
        add(1, 7, 0, 0, 0, 0, 2, 1);   // new reference, no pulse
        add(1, 0, 0, 1, 1, 0, 2, 1);   // wrap not counted outside LOCKED
        add(1, 1, 0, 1, 1, 0, 2, 1);
        add(1, 2, 0, 1, 1, 0, 2, 1);   // only 3 steps since reference
        add(1, 3, 1, 1, 1, 0, 2, 1);
        add(1, 4, 1, 1, 1, 0, 2, 1);
        add(1, 5, 1, 1, 1, 0, 2, 1);
        add(1, 5, 1, 0, 1, 0, 2, 1);   // hold
        add(1, 5, 1, 0, 1, 0, 2, 1);
        add(0, 2, 1, 0, 1, 0, 2, 1);   // gap: count ignored
        add(0, 2, 1, 0, 1, 0, 2, 1);
        add(0, 2, 1, 0, 1, 0, 2, 1);
        add(1, 6, 1, 1, 1, 0, 2, 1);
        add(1, 1, 0, 0, 1, 1, 2, 2);   // jump; leaves FAULT with ref 1

        #1 rst = 1'b1;
        #2;
        check_outs("reset", 0, 0, 0, 0, 3'd0, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].c);
            check_outs($sformatf("vec%0d", i), vecs[i].l, vecs[i].dv, vecs[i].up,
                       vecs[i].se, vecs[i].w, vecs[i].e);
        end

        // Re-lock, then async reset between edges mid-stream.
        drive(1, 2);
        drive(1, 3); drive(1, 4); drive(1, 5); drive(1, 6);
        check_outs("relock", 1, 1, 1, 0, 3'd2, 8'd2);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_outs("async_rst", 0, 0, 0, 0, 3'd0, 8'd0);
        check("async_rst.sat_err", int'(s_err_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 2);
        check_outs("post_rst_ref", 0, 0, 0, 0, 3'd0, 8'd0);
        drive(1, 3); drive(1, 4); drive(1, 5);
        check_outs("post_rst_3steps", 0, 1, 1, 0, 3'd0, 8'd0);
        drive(1, 6);
        check_outs("post_rst_4steps", 1, 1, 1, 0, 3'd0, 8'd0);

        // Repeated lock/jump cycles: 8-bit counter keeps counting, 2-bit saturates.
        p = 3'd6;
        for (int k = 1; k <= 5; k++) begin
            p = p + 3'd3;
            drive(1, p);
            exp_sat = (k > 3) ? 3 : k;
            check($sformatf("sat%0d.step_err", k), int'(step_err), 1);
            check($sformatf("sat%0d.locked", k), int'(locked), 0);
            check($sformatf("sat%0d.err_cnt", k), int'(err_cnt), k);
            check($sformatf("sat%0d.sat_err_cnt", k), int'(s_err_cnt), exp_sat);
            for (int j = 0; j < 5; j++) begin
                p = p + 3'd1;
                drive(1, p);
            end
            check($sformatf("sat%0d.relocked", k), int'(locked), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
